// File: rtl/fetch_issue_if.sv
// fetch_issue_if: instruction memory, redirect and issue signals of the fetch front-end
interface fetch_issue_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic            issue_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc_out;
  logic [8:0]      ins;
  logic            illegal;
  modport master (
    output imem_req, imem_addr, issue_valid, inst, pc_out, ins, illegal,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );
  modport slave (
    input  imem_req, imem_addr, issue_valid, inst, pc_out, ins, illegal,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: credit-limited instruction fetch with epoch-tagged flush and decode-key issue
module fetch_issue_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_issue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [8:0] NONE = 9'b0000_11111;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, last_inst_q, last_pc_q, head_inst, head_pc;
  logic [XLEN-1:0] tag_pc_q [DEPTH];
  logic [XLEN-1:0] buf_pc_q [DEPTH];
  logic [XLEN-1:0] buf_inst_q [DEPTH];
  logic [DEPTH-1:0] tag_ep_q;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d, wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] out_q, out_d, cnt_q, cnt_d;
  logic epoch_q, req, rsp, push, valid, pop, legal;
  always_comb begin
    req        = !rst && ({1'b0, out_q} + {1'b0, cnt_q}) < (AW+2)'(DEPTH) && !bus.redirect;
    rsp        = bus.imem_rvalid && out_q != '0;
    push       = rsp && tag_ep_q[tag_rd_q] == epoch_q && !bus.redirect;
    valid      = cnt_q != '0 && !bus.redirect;
    pop        = valid && !bus.stall;
    head_inst  = buf_inst_q[rd_q];
    head_pc    = buf_pc_q[rd_q];
    legal      = head_inst[1:0] == 2'b11;
    fetch_pc_d = bus.redirect ? bus.redirect_pc : fetch_pc_q + (req ? XLEN'(4) : XLEN'(0));
    tag_wr_d   = tag_wr_q + AW'(req);
    tag_rd_d   = tag_rd_q + AW'(rsp);
    out_d      = out_q + (AW+1)'(req) - (AW+1)'(rsp);
    wr_d       = bus.redirect ? '0 : wr_q + AW'(push);
    rd_d       = bus.redirect ? '0 : rd_q + AW'(pop);
    cnt_d      = bus.redirect ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      epoch_q     <= 1'b0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      out_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      last_inst_q <= '0;
      last_pc_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      epoch_q     <= epoch_q ^ bus.redirect;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      out_q       <= out_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      last_inst_q <= valid ? head_inst : last_inst_q;
      last_pc_q   <= valid ? head_pc : last_pc_q;
    end
  end
  // Payload storage needs no reset: entries are only read behind valid counters.
  always_ff @(posedge clk) begin
    if (req) begin
      tag_pc_q[tag_wr_q] <= fetch_pc_q;
      tag_ep_q[tag_wr_q] <= epoch_q;
    end
    if (push) begin
      buf_pc_q[wr_q]   <= tag_pc_q[tag_rd_q];
      buf_inst_q[wr_q] <= bus.imem_rdata;
    end
  end
  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.issue_valid = valid;
  assign bus.inst        = valid ? head_inst : last_inst_q;
  assign bus.pc_out      = valid ? head_pc : last_pc_q;
  assign bus.ins         = valid && legal ? {head_inst[30], head_inst[14:12], head_inst[6:2]} : NONE;
  assign bus.illegal     = valid && !legal;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> cnt_q < (AW+1)'(DEPTH));
endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb_fetch_issue_unit: directed stimulus with a queue scoreboard checked by an issue monitor
module tb_fetch_issue_unit;
  typedef struct packed {logic [31:0] pc; logic [31:0] w; logic [8:0] key; logic ill;} exp_t;
  localparam logic [8:0] NONE = 9'b0000_11111;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int lat = 1;
  exp_t exp_q[$];
  exp_t x;
  logic [3:0] sv = '0;
  logic [31:0] sd [4];
  logic [31:0] a;
  logic [31:0] ref_pc, ref_inst;
  logic [8:0] ref_ins;
  int nreq;
  always #5 clk = ~clk;
  fetch_issue_if bus();
  fetch_issue_unit dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [31:0] mem(input logic [31:0] ad);
    case (ad)
      32'h0:   return 32'h0000_0033;
      32'h4:   return 32'h4000_0033;
      32'h8:   return 32'h00C0_0093;
      32'hC:   return 32'hFFFF_FFFC;
      32'h10:  return 32'h0000_0033;
      default: return ad[8] ? 32'h0000_7033 : 32'h0000_0013;
    endcase
  endfunction
  always @(posedge clk) begin
    sv    <= {sv[2:0], bus.imem_req};
    sd[0] <= mem(bus.imem_addr);
    for (int i = 1; i < 4; i++) sd[i] <= sd[i-1];
  end
  assign bus.imem_rvalid = sv[lat-1];
  assign bus.imem_rdata  = sd[lat-1];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic exp_t e(input logic [31:0] pc, input logic [31:0] w, input logic [8:0] key, input logic ill);
    return {pc, w, key, ill};
  endfunction
  always @(negedge clk) begin
    if (bus.issue_valid && !bus.stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue got pc=%h exp none", bus.pc_out);
      end else begin
        x = exp_q.pop_front();
        chk("issue_pc", bus.pc_out, x.pc);
        chk("issue_inst", bus.inst, x.w);
        chk("issue_ins", 32'(bus.ins), 32'(x.key));
        chk("issue_illegal", 32'(bus.illegal), 32'(x.ill));
      end
    end else if (!bus.issue_valid) begin
      chk("bubble_ins", 32'(bus.ins), 32'(NONE));
      chk("bubble_illegal", 32'(bus.illegal), 32'(0));
    end
  end
  task automatic wait_pop(input logic [31:0] pc);
    bit found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      found = bus.issue_valid && !bus.stall && bus.pc_out == pc;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_pop_timeout got none exp pc=%h", pc);
    end
  endtask
  task automatic next_req(output logic [31:0] ad);
    bit found = 0;
    ad = '1;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      found = bus.imem_req;
      if (found) ad = bus.imem_addr;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL req_timeout got none exp request");
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(bus.imem_req), 32'(0));
    chk({tag, "_valid"}, 32'(bus.issue_valid), 32'(0));
    chk({tag, "_inst"}, bus.inst, 32'h0);
    chk({tag, "_pc"}, bus.pc_out, 32'h0);
    chk({tag, "_ins"}, 32'(bus.ins), 32'(NONE));
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'(0));
  endtask
  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    exp_q.push_back(e(32'h0, 32'h0000_0033, 9'b0000_01100, 1'b0));
    exp_q.push_back(e(32'h4, 32'h4000_0033, 9'b1000_01100, 1'b0));
    exp_q.push_back(e(32'h8, 32'h00C0_0093, 9'b0000_00100, 1'b0));
    exp_q.push_back(e(32'hC, 32'hFFFF_FFFC, 9'b0000_11111, 1'b1));
    exp_q.push_back(e(32'h10, 32'h0000_0033, 9'b0000_01100, 1'b0));
    exp_q.push_back(e(32'h14, 32'h0000_0013, 9'b0000_00100, 1'b0));
    exp_q.push_back(e(32'h18, 32'h0000_0013, 9'b0000_00100, 1'b0));
    exp_q.push_back(e(32'h100, 32'h0000_7033, 9'b0111_01100, 1'b0));
    exp_q.push_back(e(32'h104, 32'h0000_7033, 9'b0111_01100, 1'b0));
    exp_q.push_back(e(32'hFFFF_FFF8, 32'h0000_7033, 9'b0111_01100, 1'b0));
    exp_q.push_back(e(32'hFFFF_FFFC, 32'h0000_7033, 9'b0111_01100, 1'b0));
    exp_q.push_back(e(32'h0, 32'h0000_0033, 9'b0000_01100, 1'b0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("c0_req", 32'(bus.imem_req), 32'(1));
    chk("c0_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    chk("c1_addr", bus.imem_addr, 32'h4);
    @(negedge clk);
    chk("c2_valid", 32'(bus.issue_valid), 32'(1));
    chk("c2_ins", 32'(bus.ins), 32'(9'b0000_01100));
    wait_pop(32'h10);
    @(posedge clk); #1 bus.stall = 1'b1;
    nreq = 0;
    @(negedge clk);
    ref_pc = bus.pc_out;
    ref_inst = bus.inst;
    ref_ins = bus.ins;
    chk("stall_head_pc", bus.pc_out, 32'h14);
    if (bus.imem_req) nreq++;
    repeat (4) begin
      @(negedge clk);
      if (bus.imem_req) nreq++;
      chk("stall_pc_stable", bus.pc_out, ref_pc);
      chk("stall_inst_stable", bus.inst, ref_inst);
      chk("stall_ins_stable", 32'(bus.ins), 32'(ref_ins));
    end
    chk("stall_credit_le2", 32'(nreq <= 2), 32'(1));
    @(posedge clk); #1 bus.stall = 1'b0; lat = 3;
    next_req(a);
    chk("pre_redir_req0", a, 32'h1C);
    next_req(a);
    chk("pre_redir_req1", a, 32'h20);
    @(posedge clk); #1 bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    @(negedge clk);
    chk("redir_no_req", 32'(bus.imem_req), 32'(0));
    chk("redir_no_issue", 32'(bus.issue_valid), 32'(0));
    @(posedge clk); #1 bus.redirect = 1'b0;
    next_req(a);
    chk("redir_first_req", a, 32'h100);
    wait_pop(32'h104);
    @(posedge clk); #1 bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    @(posedge clk); #1 bus.redirect = 1'b0;
    next_req(a);
    chk("wrap_req0", a, 32'hFFFF_FFF8);
    next_req(a);
    chk("wrap_req1", a, 32'hFFFF_FFFC);
    next_req(a);
    chk("wrap_req2", a, 32'h0);
    wait_pop(32'h0);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk_reset("midrst");
    repeat (5) @(posedge clk);
    exp_q.push_back(e(32'h0, 32'h0000_0033, 9'b0000_01100, 1'b0));
    exp_q.push_back(e(32'h4, 32'h4000_0033, 9'b1000_01100, 1'b0));
    #1 rst = 1'b0;
    wait_pop(32'h4);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
